// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between core memory controls and a 32-bit req/ack data bus.
// Splits 64-bit accesses into two beats, lane-aligns stores, extends loads, flags misalignment/timeout.
module mem_access_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wmask,
  output logic              stall,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic [3:0]       hi_mask_q;
  logic [31:0]      hi_wdata_q;
  logic [31:0]      lo_q;
  logic [CNT_W-1:0] tcnt;

  logic        req_in;
  logic        misaligned;
  logic [3:0]  be_shift;
  logic [31:0] wd_shift;

  assign req_in   = mem_rd | mem_wr;
  assign be_shift = wmask[3:0] << addr[1:0];
  assign wd_shift = wdata[31:0] << {addr[1:0], 3'b000};

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b11:   misaligned = |addr[2:0];
      2'b10:   misaligned = |addr[1:0];
      2'b01:   misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Gated by rst so the core is released the instant reset is applied.
  assign stall = !rst && ((state == IDLE && req_in) || state == BEAT0 || state == BEAT1);

  function automatic logic [63:0] extend_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [31:0] s;
    logic [63:0] r;
    s = w >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   r = f3[2] ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'b01:   r = f3[2] ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'b10:   r = f3[2] ? {32'b0, s}       : {{32{s[31]}}, s};
      default: r = {32'b0, s};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      hi_mask_q  <= '0;
      hi_wdata_q <= '0;
      lo_q       <= '0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_in) begin
            off_q      <= addr[1:0];
            f3_q       <= funct3;
            we_q       <= mem_wr;
            hi_mask_q  <= wmask[7:4];
            hi_wdata_q <= wdata[63:32];
            rdata      <= '0;
            tcnt       <= '0;
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= mem_wr;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= mem_wr ? be_shift : 4'b0000;
              bus_wdata <= mem_wr ? wd_shift : 32'h0;
            end
          end
        end

        BEAT0: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            tcnt    <= '0;
            if (f3_q[1:0] == 2'b11) begin
              // Second beat is staged now but only requested on the next edge.
              lo_q      <= bus_rdata;
              state     <= BEAT1;
              bus_addr  <= bus_addr + ADDR_W'(4);
              bus_be    <= we_q ? hi_mask_q : 4'b0000;
              bus_wdata <= we_q ? hi_wdata_q : 32'h0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              rdata <= we_q ? 64'h0 : extend_load(bus_rdata, off_q, f3_q);
            end
          end else if (tcnt == LIMIT) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        BEAT1: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            rdata   <= we_q ? 64'h0 : {bus_rdata, lo_q};
          end else if (tcnt == LIMIT) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a short bus timeout.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        stall;
  logic [63:0] rdata;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_access_sequencer #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .wmask(wmask), .stall(stall), .rdata(rdata),
    .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd = 0; mem_wr = 0; funct3 = 3'b000; addr = '0; wdata = '0; wmask = '0;
    bus_ack = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    total_cnt++;
    if ({stall, done, err, bus_req, bus_we} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {stall, done, err, bus_req, bus_we});
    else pass_cnt++;
    total_cnt++;
    if ({rdata, bus_addr, bus_be, bus_wdata} !== '0) $display("FAIL reset_data got rdata=%h addr=%h be=%b wd=%h want=0", rdata, bus_addr, bus_be, bus_wdata);
    else pass_cnt++;
    rst = 0;
    tick();
  endtask

  task automatic test_lw_wait();
    mem_rd = 1; funct3 = 3'b010; addr = 32'h104;
    #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL lw_stall_idle got=%b want=1", stall);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h104, 4'b0000})
      $display("FAIL lw_beat got req=%b we=%b addr=%h be=%b want 1 0 00000104 0000", bus_req, bus_we, bus_addr, bus_be);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({bus_req, bus_addr, stall, done} !== {1'b1, 32'h104, 1'b1, 1'b0})
      $display("FAIL lw_wait_hold got req=%b addr=%h stall=%b done=%b want 1 00000104 1 0", bus_req, bus_addr, stall, done);
    else pass_cnt++;
    bus_ack = 1; bus_rdata = 32'h8000_0001;
    tick();
    bus_ack = 0; bus_rdata = '0;
    total_cnt++;
    if ({done, err, stall, bus_req} !== 4'b1000) $display("FAIL lw_done_ctrl got=%b want=1000", {done, err, stall, bus_req});
    else pass_cnt++;
    total_cnt++;
    if (rdata !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw_rdata got=%h want=ffffffff80000001", rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, bus_req} !== 2'b00) $display("FAIL lw_no_retrigger got done=%b req=%b want 0 0", done, bus_req);
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_sd_two_beats();
    mem_wr = 1; funct3 = 3'b011; addr = 32'h200; wdata = 64'h1122_3344_5566_7788; wmask = 8'hFF;
    tick();
    total_cnt++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h200, 4'hF, 32'h5566_7788})
      $display("FAIL sd_beat0 got req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000200 1111 55667788", bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    else pass_cnt++;
    bus_ack = 1;
    tick();
    bus_ack = 0;
    total_cnt++;
    if ({bus_req, stall} !== 2'b01) $display("FAIL sd_gap got req=%b stall=%b want 0 1", bus_req, stall);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h204, 4'hF, 32'h1122_3344})
      $display("FAIL sd_beat1 got req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000204 1111 11223344", bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    else pass_cnt++;
    bus_ack = 1;
    tick();
    bus_ack = 0;
    idle_inputs();
    total_cnt++;
    if ({done, err, rdata} !== {2'b10, 64'h0}) $display("FAIL sd_done got done=%b err=%b rdata=%h want 1 0 0", done, err, rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_sh_lane();
    mem_wr = 1; funct3 = 3'b001; addr = 32'h302; wdata = 64'hBEEF; wmask = 8'h03;
    tick();
    total_cnt++;
    if ({bus_req, bus_addr, bus_be, bus_wdata[31:16]} !== {1'b1, 32'h300, 4'b1100, 16'hBEEF})
      $display("FAIL sh_lane got req=%b addr=%h be=%b wd=%h want 1 00000300 1100 beefxxxx", bus_req, bus_addr, bus_be, bus_wdata);
    else pass_cnt++;
    bus_ack = 1;
    tick();
    bus_ack = 0;
    idle_inputs();
    total_cnt++;
    if ({done, err, bus_req} !== 3'b100) $display("FAIL sh_latency got done/err/req=%b want 100", {done, err, bus_req});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, stall} !== 2'b00) $display("FAIL sh_back_idle got done/stall=%b want 00", {done, stall});
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    mem_rd = 1; funct3 = 3'b011; addr = 32'h104;
    tick();
    total_cnt++;
    if ({bus_req, done, err, rdata} !== {3'b011, 64'h0})
      $display("FAIL ld_misaligned got req=%b done=%b err=%b rdata=%h want 0 1 1 0", bus_req, done, err, rdata);
    else pass_cnt++;
    idle_inputs();
    tick();
    total_cnt++;
    if ({done, err} !== 2'b00) $display("FAIL misaligned_pulse got done/err=%b want 00", {done, err});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    mem_rd = 1; funct3 = 3'b101; addr = 32'h10;
    tick();
    n = 0;
    while (bus_req && n < 10) begin
      n++;
      tick();
    end
    total_cnt++;
    if (n !== 4) $display("FAIL timeout_req_cycles got=%0d want=4", n);
    else pass_cnt++;
    total_cnt++;
    if ({done, err, bus_req, stall} !== 4'b1100) $display("FAIL timeout_done got done/err/req/stall=%b want 1100", {done, err, bus_req, stall});
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_load_extend();
    // LH from upper lane: sign-extended
    mem_rd = 1; funct3 = 3'b001; addr = 32'h402;
    tick();
    bus_ack = 1; bus_rdata = 32'h8001_1234;
    tick();
    idle_inputs();
    total_cnt++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_8001) $display("FAIL lh_sign got=%h want=ffffffffffff8001", rdata);
    else pass_cnt++;
    tick();
    // LHU from lower lane: zero-extended
    mem_rd = 1; funct3 = 3'b101; addr = 32'h400;
    tick();
    bus_ack = 1; bus_rdata = 32'h8001_F234;
    tick();
    idle_inputs();
    total_cnt++;
    if (rdata !== 64'h0000_0000_0000_F234) $display("FAIL lhu_zero got=%h want=000000000000f234", rdata);
    else pass_cnt++;
    tick();
    // LWU: zero-extended word
    mem_rd = 1; funct3 = 3'b110; addr = 32'h408;
    tick();
    bus_ack = 1; bus_rdata = 32'h9000_0002;
    tick();
    idle_inputs();
    total_cnt++;
    if (rdata !== 64'h0000_0000_9000_0002) $display("FAIL lwu_zero got=%h want=0000000090000002", rdata);
    else pass_cnt++;
    tick();
    // LD: two beats assembled low then high
    mem_rd = 1; funct3 = 3'b011; addr = 32'h100;
    tick();
    bus_ack = 1; bus_rdata = 32'h89AB_CDEF;
    tick();
    bus_ack = 0; bus_rdata = '0;
    tick();
    total_cnt++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {2'b10, 32'h104, 4'b0000})
      $display("FAIL ld_beat1 got req=%b we=%b addr=%h be=%b want 1 0 00000104 0000", bus_req, bus_we, bus_addr, bus_be);
    else pass_cnt++;
    bus_ack = 1; bus_rdata = 32'h0123_4567;
    tick();
    idle_inputs();
    total_cnt++;
    if ({done, rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) $display("FAIL ld_rdata got done=%b rdata=%h want 1 0123456789abcdef", done, rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_access();
    mem_rd = 1; funct3 = 3'b011; addr = 32'h600;
    tick();
    bus_ack = 1;
    tick();
    bus_ack = 0;
    tick();
    total_cnt++;
    if ({bus_req, stall} !== 2'b11) $display("FAIL rst_pre got req/stall=%b want 11", {bus_req, stall});
    else pass_cnt++;
    rst = 1;
    #1;
    total_cnt++;
    if ({bus_req, stall, done} !== 3'b000) $display("FAIL rst_async got req/stall/done=%b want 000", {bus_req, stall, done});
    else pass_cnt++;
    idle_inputs();
    tick();
    rst = 0;
    tick();
    tick();
    total_cnt++;
    if ({bus_req, stall, done, err} !== 4'b0000) $display("FAIL rst_idle_after got req/stall/done/err=%b want 0000", {bus_req, stall, done, err});
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    #2;
    test_reset();
    test_lw_wait();
    test_sd_two_beats();
    test_sh_lane();
    test_misaligned();
    test_timeout();
    test_load_extend();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
